// File: rtl/ecc_scrub_ctrl_pkg.sv
// ecc_scrub_ctrl_pkg
//   Shared definitions for the ECC scrubber: codeword geometry, the
//   controller state encoding, the SEC-DED syndrome column table and the
//   check-bit generator used both for checking and for re-encoding.
//   Codeword layout: {p[4:0], d[10:0]}; p[4] is overall parity.
package ecc_scrub_ctrl_pkg;

    localparam int CW_W   = 16;
    localparam int DATA_W = 11;
    localparam int PAR_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_RD   = 3'd2,
        ST_CHK  = 3'd3,
        ST_WR   = 3'd4,
        ST_NXT  = 3'd5
    } scrub_state_t;

    // Syndrome column of each data bit, d0 in the low nibble.
    // Power-of-two columns belong to p[3:0] and are deliberately absent.
    localparam logic [4*DATA_W-1:0] SYND_COL = {
        4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h7, 4'h6, 4'h5, 4'h3
    };

    function automatic logic [3:0] col_of(input int i);
        return SYND_COL[i*4 +: 4];
    endfunction

    // p[k] (k<4) is the XOR of every data bit whose column has bit k set;
    // p[4] closes overall parity across data and p[3:0].
    function automatic logic [PAR_W-1:0] secded_parity(input logic [DATA_W-1:0] d);
        logic [PAR_W-1:0] p;
        p = '0;
        for (int i = 0; i < DATA_W; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (SYND_COL[4*i+k]) begin
                    p[k] = p[k] ^ d[i];
                end
            end
        end
        p[4] = ^{d, p[3:0]};
        return p;
    endfunction

endpackage

// File: rtl/ecc_scrub_ctrl_if.sv
// ecc_scrub_ctrl_if
//   Scrubber side of the shared memory port.
//   master (scrubber): mem_req, mem_we, mem_addr, mem_wdata out; mem_gnt, mem_rdata in
//   slave  (arbiter/memory): the mirror image.
//
// Handshake: mem_req is the valid, mem_gnt the ready. A transfer happens in
// exactly the cycle where mem_req && mem_gnt. While mem_req is high and
// mem_gnt low the master holds mem_we, mem_addr and mem_wdata stable; mem_we
// and mem_wdata are meaningful only while mem_req is high. Read data for a
// granted read appears on mem_rdata in the following cycle only. The one
// case where the master withdraws an ungranted request is a write-back made
// stale by a CPU write to the same address.
interface ecc_scrub_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic                               mem_req;
    logic                               mem_we;
    logic [ADDR_W-1:0]                  mem_addr;
    logic [ecc_scrub_ctrl_pkg::CW_W-1:0] mem_wdata;
    logic                               mem_gnt;
    logic [ecc_scrub_ctrl_pkg::CW_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rdata
    );
endinterface

// File: rtl/ecc_scrub_ctrl_secded_check.sv
// ecc_scrub_ctrl_secded_check
//   Combinational SEC-DED classifier for one 16-bit codeword.
//   cw        in  codeword {p[4:0], d[10:0]}
//   clean     out no error
//   sec       out single-bit error, data_corr holds the repaired data
//   ded       out uncorrectable error
//   data_corr out data bits after correction (unchanged unless a data bit flipped)
module ecc_scrub_ctrl_secded_check
    import ecc_scrub_ctrl_pkg::*;
(
    input  logic [CW_W-1:0]   cw,
    output logic              clean,
    output logic              sec,
    output logic              ded,
    output logic [DATA_W-1:0] data_corr
);

    logic [DATA_W-1:0] d;
    logic [PAR_W-1:0]  p_st;
    logic [PAR_W-1:0]  p_re;
    logic [3:0]        syn;
    logic              ov;
    logic              par_only;
    logic              col_hit;
    logic [DATA_W-1:0] flip;

    assign d    = cw[DATA_W-1:0];
    assign p_st = cw[CW_W-1:DATA_W];
    assign p_re = secded_parity(d);
    assign syn  = p_st[3:0] ^ p_re[3:0];
    assign ov   = ^cw;

    // Zero or one-hot syndrome with odd overall parity: a check bit flipped,
    // the data bits are intact.
    assign par_only = ((syn & (syn - 4'd1)) == 4'd0);

    always_comb begin
        flip    = '0;
        col_hit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (syn == col_of(i)) begin
                flip[i] = 1'b1;
                col_hit = 1'b1;
            end
        end
    end

    always_comb begin
        clean     = !ov && (syn == 4'd0);
        sec       = ov && (par_only || col_hit);
        // Odd parity with an unmapped syndrome falls through to DED as well.
        ded       = !clean && !sec;
        data_corr = (sec && !par_only) ? (d ^ flip) : d;
    end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl
//   Background scrubber: walks addresses 0..DEPTH-1 through the shared
//   memory port, rewrites words with a single-bit error and logs words with
//   an uncorrectable error.
//   clk, rst_n     clock, asynchronous active-low reset
//   scrub_en       level enable; a word already started always completes
//   interval       idle cycles between words (0 = back-to-back)
//   mem            shared memory port (master side)
//   cpu_wr/_addr   CPU write snoop; a hit cancels a pending write-back
//   sec_count      corrected errors, saturating
//   ded_count      uncorrectable errors, saturating
//   ded_flag       sticky uncorrectable-error flag
//   ded_addr       address of the latest uncorrectable error
//   pass_done      one-cycle pulse as the address wraps DEPTH-1 -> 0
//   dbg_state      current controller state
module ecc_scrub_ctrl
    import ecc_scrub_ctrl_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 8,
    parameter int INTERVAL_W = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scrub_en,
    input  logic [INTERVAL_W-1:0] interval,
    ecc_scrub_ctrl_if.master      mem,
    input  logic                  cpu_wr,
    input  logic [ADDR_W-1:0]     cpu_wr_addr,
    output logic [CNT_W-1:0]      sec_count,
    output logic [CNT_W-1:0]      ded_count,
    output logic                  ded_flag,
    output logic [ADDR_W-1:0]     ded_addr,
    output logic                  pass_done,
    output scrub_state_t          dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    scrub_state_t          state_q;
    scrub_state_t          state_d;
    logic [ADDR_W-1:0]     addr_q;
    logic [INTERVAL_W-1:0] gap_q;
    logic [DATA_W-1:0]     wr_data_q;

    logic                  chk_clean;
    logic                  chk_sec;
    logic                  chk_ded;
    logic [DATA_W-1:0]     chk_data;
    logic                  snoop_hit;

    ecc_scrub_ctrl_secded_check u_check (
        .cw        (mem.mem_rdata),
        .clean     (chk_clean),
        .sec       (chk_sec),
        .ded       (chk_ded),
        .data_corr (chk_data)
    );

    // A CPU write to the word being scrubbed makes our copy stale.
    assign snoop_hit = cpu_wr && (cpu_wr_addr == addr_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (scrub_en) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (!scrub_en)          state_d = ST_IDLE;
                else if (gap_q == '0)   state_d = ST_RD;
            end
            ST_RD: begin
                if (mem.mem_gnt) state_d = ST_CHK;
            end
            ST_CHK: begin
                if (chk_clean || chk_ded || snoop_hit) state_d = ST_NXT;
                else                                   state_d = ST_WR;
            end
            ST_WR: begin
                if (snoop_hit || mem.mem_gnt) state_d = ST_NXT;
            end
            ST_NXT: begin
                state_d = scrub_en ? ST_GAP : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs. The write request is withdrawn in the very cycle a snoop hit
    // is seen so a stale codeword can never be granted.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = addr_q;
        mem.mem_wdata = '0;
        pass_done     = 1'b0;
        dbg_state     = state_q;
        unique case (state_q)
            ST_RD: begin
                mem.mem_req = 1'b1;
            end
            ST_WR: begin
                mem.mem_req   = !snoop_hit;
                mem.mem_we    = !snoop_hit;
                mem.mem_wdata = {secded_parity(wr_data_q), wr_data_q};
            end
            ST_NXT: begin
                pass_done = (addr_q == LAST_ADDR);
            end
            default: ;
        endcase
    end

    // Address, gap counter and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            gap_q     <= '0;
            wr_data_q <= '0;
            sec_count <= '0;
            ded_count <= '0;
            ded_flag  <= 1'b0;
            ded_addr  <= '0;
        end else begin
            if ((state_q == ST_IDLE || state_q == ST_NXT) && scrub_en) begin
                gap_q <= interval;
            end else if (state_q == ST_GAP && gap_q != '0) begin
                gap_q <= gap_q - INTERVAL_W'(1);
            end

            if (state_q == ST_NXT) begin
                addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
            end

            if (state_q == ST_CHK) begin
                wr_data_q <= chk_data;
                // Counted even if the write-back is later cancelled.
                if (chk_sec && sec_count != '1) begin
                    sec_count <= sec_count + CNT_W'(1);
                end
                if (chk_ded) begin
                    if (ded_count != '1) ded_count <= ded_count + CNT_W'(1);
                    ded_flag <= 1'b1;
                    ded_addr <= addr_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb_ecc_scrub_ctrl
//   Bench for ecc_scrub_ctrl with DEPTH=4. A behavioural memory answers the
//   shared port; expectations come from the number of bits the bench itself
//   flipped in each stored codeword (0 clean, 1 corrected, 2 uncorrectable).
module tb_ecc_scrub_ctrl;
    import ecc_scrub_ctrl_pkg::*;

    localparam int DEPTH      = 4;
    localparam int ADDR_W     = 8;
    localparam int INTERVAL_W = 16;
    localparam int CNT_W      = 16;

    // ---------------- clock / reset / DUT ----------------
    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  scrub_en = 1'b0;
    logic [INTERVAL_W-1:0] interval = '0;
    logic                  cpu_wr = 1'b0;
    logic [ADDR_W-1:0]     cpu_wr_addr = '0;
    logic [15:0]           cpu_wr_data = '0;
    logic [CNT_W-1:0]      sec_count;
    logic [CNT_W-1:0]      ded_count;
    logic                  ded_flag;
    logic [ADDR_W-1:0]     ded_addr;
    logic                  pass_done;
    scrub_state_t          dbg_state;

    always #5 clk = ~clk;

    ecc_scrub_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    ecc_scrub_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INTERVAL_W(INTERVAL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en), .interval(interval),
        .mem(bus), .cpu_wr(cpu_wr), .cpu_wr_addr(cpu_wr_addr),
        .sec_count(sec_count), .ded_count(ded_count), .ded_flag(ded_flag),
        .ded_addr(ded_addr), .pass_done(pass_done), .dbg_state(dbg_state)
    );

    // ---------------- memory / arbiter model ----------------
    logic [15:0]       mem [256];
    logic [15:0]       rdata_r = '0;
    logic              gnt_en = 1'b1;
    logic              block_wr = 1'b0;
    logic              rand_gnt = 1'b0;
    logic              gnt_coin = 1'b1;
    int unsigned       cyc = 0;
    int unsigned       pd_cnt = 0;
    logic [ADDR_W-1:0] got_rd_q[$];
    int unsigned       rd_cyc_q[$];
    logic [ADDR_W+15:0] got_wr_q[$];

    assign bus.mem_gnt   = gnt_en && !(block_wr && bus.mem_we) && (!rand_gnt || gnt_coin);
    assign bus.mem_rdata = rdata_r;

    always @(negedge clk) gnt_coin = 1'($urandom_range(0, 1));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pass_done) pd_cnt <= pd_cnt + 1;
        if (bus.mem_req && bus.mem_gnt) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr] <= bus.mem_wdata;
                got_wr_q.push_back({bus.mem_addr, bus.mem_wdata});
            end else begin
                rdata_r <= mem[bus.mem_addr];
                got_rd_q.push_back(bus.mem_addr);
                rd_cyc_q.push_back(cyc);
            end
        end
        if (cpu_wr) mem[cpu_wr_addr] <= cpu_wr_data;
    end

    // ---------------- reference model / scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [15:0]        golden [DEPTH];
    logic [15:0]        mask [DEPTH];
    int                 exp_sec = 0;
    int                 exp_ded = 0;
    logic               exp_flag = 1'b0;
    logic [ADDR_W-1:0]  exp_ded_addr = '0;
    logic [ADDR_W-1:0]  exp_rd_q[$];
    logic [ADDR_W+15:0] exp_wr_q[$];
    int                 rd_base, wr_base;
    int unsigned        pd_base;
    logic [ADDR_W-1:0]  pd_addr;

    function automatic logic [15:0] ref_encode(input logic [10:0] d);
        logic p0, p1, p2, p3, p4;
        p0 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
        p1 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
        p2 = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        p3 = ^d[10:4];
        p4 = (^d) ^ p0 ^ p1 ^ p2 ^ p3;
        return {p4, p3, p2, p1, p0, d};
    endfunction

    function automatic logic [15:0] rand_mask(input int nbits);
        int b0, b1;
        b0 = $urandom_range(0, 15);
        b1 = (b0 + $urandom_range(1, 15)) % 16;
        if (nbits == 0) return 16'h0;
        if (nbits == 1) return 16'h1 << b0;
        return (16'h1 << b0) | (16'h1 << b1);
    endfunction

    // Expected outcome of one full pass, walking 0..DEPTH-1 in order.
    task automatic model_pass(input int cancel_addr);
        exp_rd_q.delete();
        exp_wr_q.delete();
        for (int a = 0; a < DEPTH; a++) begin
            exp_rd_q.push_back(ADDR_W'(a));
            if ($countones(mask[a]) == 1) begin
                exp_sec++;
                if (a != cancel_addr) exp_wr_q.push_back({ADDR_W'(a), golden[a]});
                mask[a] = 16'h0;
            end else if ($countones(mask[a]) >= 2) begin
                exp_ded++;
                exp_flag = 1'b1;
                exp_ded_addr = ADDR_W'(a);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cpu_write(input int a, input logic [15:0] data);
        @(negedge clk);
        cpu_wr = 1'b1;
        cpu_wr_addr = ADDR_W'(a);
        cpu_wr_data = data;
        @(negedge clk);
        cpu_wr = 1'b0;
    endtask

    task automatic fill_clean();
        for (int a = 0; a < DEPTH; a++) begin
            golden[a] = ref_encode(11'($urandom_range(0, 2047)));
            mask[a]   = 16'h0;
        end
    endtask

    task automatic load_mem();
        for (int a = 0; a < DEPTH; a++) cpu_write(a, golden[a] ^ mask[a]);
    endtask

    task automatic start_scrub();
        rd_base = got_rd_q.size();
        wr_base = got_wr_q.size();
        pd_base = pd_cnt;
        @(negedge clk);
        scrub_en = 1'b1;
    endtask

    task automatic wait_pass_end();
        int n = 0;
        while (pass_done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pass_done !== 1'b1) begin
            errors++;
            $display("FAIL pass_timeout: pass_done=%b after %0d cycles, required 1", pass_done, n);
        end
        pd_addr = bus.mem_addr;
        scrub_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_pass();
        start_scrub();
        wait_pass_end();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        scrub_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, required 0", bus.mem_we); end
        checks++; if (sec_count !== '0) begin errors++; $display("FAIL reset_sec: got %0d, required 0", sec_count); end
        checks++; if (ded_count !== '0) begin errors++; $display("FAIL reset_ded: got %0d, required 0", ded_count); end
        checks++; if (ded_flag !== 1'b0 || ded_addr !== '0) begin errors++; $display("FAIL reset_ded_log: flag %b addr %0d, required 0 0", ded_flag, ded_addr); end
        checks++; if (pass_done !== 1'b0) begin errors++; $display("FAIL reset_pass_done: got %b, required 0", pass_done); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_pass();
        fill_clean();
        load_mem();
        interval = '0;
        model_pass(-1);
        run_pass();
        checks++; if (got_rd_q.size() - rd_base != DEPTH) begin errors++; $display("FAIL clean_rd_count: got %0d, required %0d", got_rd_q.size() - rd_base, DEPTH); end
        for (int i = 0; i < DEPTH && rd_base + i < got_rd_q.size(); i++) begin
            checks++; if (got_rd_q[rd_base+i] !== exp_rd_q[i]) begin errors++; $display("FAIL clean_rd_addr[%0d]: got %0d, required %0d", i, got_rd_q[rd_base+i], exp_rd_q[i]); end
            if (i > 0) begin
                checks++; if (rd_cyc_q[rd_base+i] - rd_cyc_q[rd_base+i-1] != 4) begin errors++; $display("FAIL clean_spacing[%0d]: got %0d cycles, required 4", i, rd_cyc_q[rd_base+i] - rd_cyc_q[rd_base+i-1]); end
            end
        end
        checks++; if (got_wr_q.size() != wr_base) begin errors++; $display("FAIL clean_writes: got %0d, required 0", got_wr_q.size() - wr_base); end
        checks++; if (pd_cnt - pd_base != 1 || pd_addr !== ADDR_W'(DEPTH - 1)) begin errors++; $display("FAIL clean_pass_done: got %0d pulses at addr %0d, required 1 at %0d", pd_cnt - pd_base, pd_addr, DEPTH - 1); end
        checks++; if (sec_count !== 0 || ded_count !== 0) begin errors++; $display("FAIL clean_counts: sec %0d ded %0d, required 0 0", sec_count, ded_count); end
    endtask

    task automatic test_sec();
        fill_clean();
        mask[2] = 16'h0020;
        load_mem();
        model_pass(-1);
        run_pass();
        checks++; if (got_wr_q.size() - wr_base != exp_wr_q.size()) begin errors++; $display("FAIL sec_write_count: got %0d, required %0d", got_wr_q.size() - wr_base, exp_wr_q.size()); end
        else if (exp_wr_q.size() > 0) begin
            checks++; if (got_wr_q[wr_base] !== exp_wr_q[0]) begin errors++; $display("FAIL sec_write: got %h, required %h", got_wr_q[wr_base], exp_wr_q[0]); end
        end
        checks++; if (mem[2] !== golden[2]) begin errors++; $display("FAIL sec_mem: got %h, required %h", mem[2], golden[2]); end
        checks++; if (sec_count !== CNT_W'(exp_sec)) begin errors++; $display("FAIL sec_count: got %0d, required %0d", sec_count, exp_sec); end
        checks++; if (ded_flag !== exp_flag) begin errors++; $display("FAIL sec_ded_flag: got %b, required %b", ded_flag, exp_flag); end
    endtask

    task automatic test_ded();
        fill_clean();
        mask[1] = 16'h0081;
        load_mem();
        model_pass(-1);
        run_pass();
        checks++; if (got_wr_q.size() != wr_base) begin errors++; $display("FAIL ded_writes: got %0d, required 0", got_wr_q.size() - wr_base); end
        checks++; if (ded_count !== CNT_W'(exp_ded)) begin errors++; $display("FAIL ded_count: got %0d, required %0d", ded_count, exp_ded); end
        checks++; if (ded_flag !== exp_flag) begin errors++; $display("FAIL ded_flag: got %b, required %b", ded_flag, exp_flag); end
        checks++; if (ded_addr !== exp_ded_addr) begin errors++; $display("FAIL ded_addr: got %0d, required %0d", ded_addr, exp_ded_addr); end
        checks++; if (sec_count !== CNT_W'(exp_sec)) begin errors++; $display("FAIL ded_sec_count: got %0d, required %0d", sec_count, exp_sec); end
    endtask

    task automatic test_interval();
        int gap;
        gap = $urandom_range(1, 6);
        interval = INTERVAL_W'(gap);
        fill_clean();
        load_mem();
        model_pass(-1);
        run_pass();
        checks++; if (got_rd_q.size() - rd_base != DEPTH) begin errors++; $display("FAIL interval_rd_count: got %0d, required %0d", got_rd_q.size() - rd_base, DEPTH); end
        for (int i = 1; i < DEPTH && rd_base + i < got_rd_q.size(); i++) begin
            checks++; if (rd_cyc_q[rd_base+i] - rd_cyc_q[rd_base+i-1] != gap + 4) begin errors++; $display("FAIL interval_spacing[%0d]: got %0d cycles, required %0d", i, rd_cyc_q[rd_base+i] - rd_cyc_q[rd_base+i-1], gap + 4); end
        end
        interval = '0;
    endtask

    task automatic test_random();
        rand_gnt = 1'b1;
        for (int p = 0; p < 3; p++) begin
            interval = INTERVAL_W'($urandom_range(0, 3));
            fill_clean();
            for (int a = 0; a < DEPTH; a++) mask[a] = rand_mask($urandom_range(0, 2));
            load_mem();
            model_pass(-1);
            run_pass();
            checks++; if (got_rd_q.size() - rd_base != DEPTH) begin errors++; $display("FAIL rand%0d_rd_count: got %0d, required %0d", p, got_rd_q.size() - rd_base, DEPTH); end
            checks++; if (got_wr_q.size() - wr_base != exp_wr_q.size()) begin errors++; $display("FAIL rand%0d_write_count: got %0d, required %0d", p, got_wr_q.size() - wr_base, exp_wr_q.size()); end
            else begin
                foreach (exp_wr_q[i]) begin
                    checks++; if (got_wr_q[wr_base+i] !== exp_wr_q[i]) begin errors++; $display("FAIL rand%0d_write[%0d]: got %h, required %h", p, i, got_wr_q[wr_base+i], exp_wr_q[i]); end
                end
            end
            checks++; if (sec_count !== CNT_W'(exp_sec) || ded_count !== CNT_W'(exp_ded)) begin errors++; $display("FAIL rand%0d_counts: sec %0d ded %0d, required %0d %0d", p, sec_count, ded_count, exp_sec, exp_ded); end
            checks++; if (ded_flag !== exp_flag || ded_addr !== exp_ded_addr) begin errors++; $display("FAIL rand%0d_ded_log: flag %b addr %0d, required %b %0d", p, ded_flag, ded_addr, exp_flag, exp_ded_addr); end
        end
        rand_gnt = 1'b0;
        interval = '0;
    endtask

    task automatic test_snoop();
        int n = 0;
        logic [15:0] cpu_cw;
        fill_clean();
        mask[3] = rand_mask(1);
        load_mem();
        model_pass(3);
        block_wr = 1'b1;
        start_scrub();
        while (!(bus.mem_req === 1'b1 && bus.mem_we === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== ADDR_W'(3)) begin errors++; $display("FAIL snoop_wr_pending: we %b addr %0d, required 1 3", bus.mem_we, bus.mem_addr); end
        cpu_cw = ref_encode(11'($urandom_range(0, 2047)));
        golden[3] = cpu_cw;
        cpu_wr = 1'b1;
        cpu_wr_addr = ADDR_W'(3);
        cpu_wr_data = cpu_cw;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL snoop_req_drop: got %b, required 0", bus.mem_req); end
        @(negedge clk);
        cpu_wr = 1'b0;
        block_wr = 1'b0;
        wait_pass_end();
        checks++; if (got_wr_q.size() != wr_base) begin errors++; $display("FAIL snoop_writes: got %0d, required 0", got_wr_q.size() - wr_base); end
        checks++; if (mem[3] !== cpu_cw) begin errors++; $display("FAIL snoop_mem: got %h, required %h", mem[3], cpu_cw); end
        checks++; if (sec_count !== CNT_W'(exp_sec)) begin errors++; $display("FAIL snoop_sec_count: got %0d, required %0d", sec_count, exp_sec); end
    endtask

    task automatic test_gnt_stall();
        int n = 0;
        logic [ADDR_W-1:0] held;
        fill_clean();
        load_mem();
        model_pass(-1);
        gnt_en = 1'b0;
        start_scrub();
        while (bus.mem_req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        held = bus.mem_addr;
        checks++; if (held !== '0) begin errors++; $display("FAIL stall_first_addr: got %0d, required 0", held); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== held) begin errors++; $display("FAIL stall_hold[%0d]: req %b we %b addr %0d, required 1 0 %0d", i, bus.mem_req, bus.mem_we, bus.mem_addr, held); end
        end
        gnt_en = 1'b1;
        wait_pass_end();
        checks++; if (got_rd_q.size() - rd_base != DEPTH) begin errors++; $display("FAIL stall_rd_count: got %0d, required %0d", got_rd_q.size() - rd_base, DEPTH); end
        for (int i = 0; i < DEPTH && rd_base + i < got_rd_q.size(); i++) begin
            checks++; if (got_rd_q[rd_base+i] !== exp_rd_q[i]) begin errors++; $display("FAIL stall_rd_addr[%0d]: got %0d, required %0d", i, got_rd_q[rd_base+i], exp_rd_q[i]); end
        end
    endtask

    task automatic test_reset_during_wr();
        int n = 0;
        fill_clean();
        mask[0] = rand_mask(1);
        load_mem();
        block_wr = 1'b1;
        start_scrub();
        while (!(bus.mem_req === 1'b1 && bus.mem_we === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        scrub_en = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rstwr_req: req %b we %b, required 0 0", bus.mem_req, bus.mem_we); end
        checks++; if (sec_count !== '0 || ded_count !== '0 || ded_flag !== 1'b0) begin errors++; $display("FAIL rstwr_status: sec %0d ded %0d flag %b, required 0 0 0", sec_count, ded_count, ded_flag); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rstwr_state: got %0d, required %0d", dbg_state, ST_IDLE); end
        @(negedge clk);
        rst_n = 1'b1;
        block_wr = 1'b0;
        exp_sec = 0;
        exp_ded = 0;
        exp_flag = 1'b0;
        exp_ded_addr = '0;
        model_pass(-1);
        run_pass();
        checks++; if (got_rd_q.size() - rd_base != DEPTH || got_rd_q[rd_base] !== '0) begin errors++; $display("FAIL rstwr_restart: %0d reads, first addr %0d, required %0d reads from 0", got_rd_q.size() - rd_base, got_rd_q[rd_base], DEPTH); end
        checks++; if (got_wr_q.size() - wr_base != 1 || got_wr_q[wr_base] !== exp_wr_q[0]) begin errors++; $display("FAIL rstwr_write: %0d writes, first %h, required 1 of %h", got_wr_q.size() - wr_base, got_wr_q[wr_base], exp_wr_q[0]); end
        checks++; if (sec_count !== CNT_W'(exp_sec)) begin errors++; $display("FAIL rstwr_sec_count: got %0d, required %0d", sec_count, exp_sec); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_clean_pass();
        test_sec();
        test_ded();
        test_interval();
        test_random();
        test_snoop();
        test_gnt_stall();
        test_reset_during_wr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
